// File: rtl/ram_assign_pkg.sv
// Shared defaults and word/address typedefs for the dual-port scratch RAM.
package ram_assign_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_ADDR_WIDTH = 8;
  localparam int DEF_DEPTH      = 2 ** DEF_ADDR_WIDTH;

  typedef logic [DEF_DATA_WIDTH-1:0] data_t;
  typedef logic [DEF_ADDR_WIDTH-1:0] addr_t;

endpackage

// File: rtl/ram_assign_dp.sv
// True dual-port synchronous RAM with write-first reads, cross-port forwarding
// and port-A priority on same-address simultaneous writes.
module ram_assign_dp
  import ram_assign_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] add_a,
  input  logic [DATA_WIDTH-1:0] din_a,
  input  logic                  we_a,
  output logic [DATA_WIDTH-1:0] dout_a,
  input  logic [ADDR_WIDTH-1:0] add_b,
  input  logic [DATA_WIDTH-1:0] din_b,
  input  logic                  we_b,
  output logic [DATA_WIDTH-1:0] dout_b
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH] = '{default: '0};

  logic                  same_addr;
  logic                  b_write_ok;
  logic [DATA_WIDTH-1:0] rd_a;
  logic [DATA_WIDTH-1:0] rd_b;

  assign same_addr  = (add_a == add_b);
  assign b_write_ok = we_b && !(we_a && same_addr);

  // Each port reads the word as it will look once this edge's writes land.
  always_comb begin
    rd_a = mem[add_a];
    rd_b = mem[add_b];
    if (we_a) begin
      rd_a = din_a;
    end else if (we_b && same_addr) begin
      rd_a = din_b;
    end
    if (we_a && same_addr) begin
      rd_b = din_a;
    end else if (we_b) begin
      rd_b = din_b;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dout_a <= '0;
      dout_b <= '0;
    end else begin
      if (we_a) begin
        mem[add_a] <= din_a;
      end
      if (b_write_ok) begin
        mem[add_b] <= din_b;
      end
      dout_a <= rd_a;
      dout_b <= rd_b;
    end
  end

endmodule

// File: tb/tb_ram_assign_dp.sv
// Self-checking bench for ram_assign_dp: array model compared every cycle,
// plus directed vectors with literal expectations.
module tb_ram_assign_dp;
  import ram_assign_pkg::*;

  logic  clk = 1'b0;
  logic  rst;
  addr_t add_a, add_b;
  data_t din_a, din_b;
  logic  we_a, we_b;
  data_t dout_a, dout_b;

  int n_vectors = 0;
  int n_miscompares = 0;

  data_t model_mem [DEF_DEPTH];
  data_t exp_a, exp_b;
  logic  model_valid = 1'b0;

  ram_assign_dp dut (
    .clk    (clk),
    .rst    (rst),
    .add_a  (add_a),
    .din_a  (din_a),
    .we_a   (we_a),
    .dout_a (dout_a),
    .add_b  (add_b),
    .din_b  (din_b),
    .we_b   (we_b),
    .dout_b (dout_b)
  );

  always #5 clk = ~clk;

  // Model: apply B's write, then A's (so A wins a tie), then both ports read.
  always @(posedge clk) begin
    if (rst) begin
      exp_a = '0;
      exp_b = '0;
    end else begin
      if (we_b) model_mem[add_b] = din_b;
      if (we_a) model_mem[add_a] = din_a;
      exp_a = model_mem[add_a];
      exp_b = model_mem[add_b];
    end
    model_valid = 1'b1;
  end

  task automatic checkOutput(input string name, input data_t actual, input data_t expected);
    n_vectors++;
    if (actual !== expected) begin
      n_miscompares++;
      $display("[TB] FAIL %s: got 0x%02h, expected 0x%02h at %0t", name, actual, expected, $time);
    end
  endtask

  always @(negedge clk) begin
    if (model_valid) begin
      checkOutput("model_dout_a", dout_a, exp_a);
      checkOutput("model_dout_b", dout_b, exp_b);
    end
  end

  task automatic applyStimulus(input logic r,
                               input addr_t aa, input data_t da, input logic wa,
                               input addr_t ab, input data_t db, input logic wb);
    rst   = r;
    add_a = aa;
    din_a = da;
    we_a  = wa;
    add_b = ab;
    din_b = db;
    we_b  = wb;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < DEF_DEPTH; i++) model_mem[i] = '0;
    applyStimulus(1'b1, 8'h00, 8'hAA, 1'b1, 8'h00, 8'h55, 1'b1);

    // Reset with writes presented: outputs zero, nothing stored
    tick();
    tick();
    checkOutput("reset_dout_a", dout_a, 8'h00);
    checkOutput("reset_dout_b", dout_b, 8'h00);
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b0, 8'(i), 8'h00, 1'b0, 8'(i), 8'h00, 1'b0);
      tick();
      checkOutput("post_reset_read_a", dout_a, 8'h00);
      checkOutput("post_reset_read_b", dout_b, 8'h00);
    end

    // Same-address dual write: port A wins
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b0, 8'(i), 8'(3 * i), 1'b1, 8'(i), 8'(5 * i), 1'b1);
      tick();
      checkOutput("dual_wr_dout_a", dout_a, 8'(3 * i));
      checkOutput("dual_wr_dout_b", dout_b, 8'(3 * i));
      applyStimulus(1'b0, 8'(i), 8'h00, 1'b0, 8'(i), 8'h00, 1'b0);
      tick();
      checkOutput("dual_idle_dout_b", dout_b, 8'(3 * i));
    end
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b0, 8'h80, 8'h00, 1'b0, 8'(i), 8'h00, 1'b0);
      tick();
      checkOutput("readback_b", dout_b, 8'(3 * i));
    end

    // Distinct-address dual write
    applyStimulus(1'b0, 8'h10, 8'h11, 1'b1, 8'h20, 8'h22, 1'b1);
    tick();
    checkOutput("wr_first_a", dout_a, 8'h11);
    checkOutput("wr_first_b", dout_b, 8'h22);
    applyStimulus(1'b0, 8'h20, 8'h00, 1'b0, 8'h10, 8'h00, 1'b0);
    tick();
    checkOutput("cross_read_a", dout_a, 8'h22);
    checkOutput("cross_read_b", dout_b, 8'h11);

    // Cross-port forwarding in both directions
    applyStimulus(1'b0, 8'h40, 8'h5A, 1'b1, 8'h40, 8'hEE, 1'b0);
    tick();
    checkOutput("fwd_a_to_b", dout_b, 8'h5A);
    applyStimulus(1'b0, 8'h41, 8'hEE, 1'b0, 8'h41, 8'h66, 1'b1);
    tick();
    checkOutput("fwd_b_to_a", dout_a, 8'h66);

    // Registered latency at the top address
    applyStimulus(1'b0, 8'hFF, 8'h77, 1'b1, 8'h00, 8'h00, 1'b0);
    tick();
    applyStimulus(1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0);
    tick();
    checkOutput("latency_addr0", dout_a, 8'h00);
    applyStimulus(1'b0, 8'hFF, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0);
    #1;
    checkOutput("latency_not_before", dout_a, 8'h00);
    tick();
    checkOutput("latency_after_edge", dout_a, 8'h77);

    // Reset mid-operation drops the concurrent write, keeps stored data
    applyStimulus(1'b0, 8'h05, 8'h33, 1'b1, 8'h05, 8'h00, 1'b0);
    tick();
    checkOutput("store_33", dout_a, 8'h33);
    applyStimulus(1'b1, 8'h05, 8'h99, 1'b1, 8'h05, 8'h00, 1'b0);
    tick();
    checkOutput("mid_reset_a", dout_a, 8'h00);
    checkOutput("mid_reset_b", dout_b, 8'h00);
    applyStimulus(1'b0, 8'h05, 8'h00, 1'b0, 8'h05, 8'h00, 1'b0);
    tick();
    checkOutput("after_reset_a", dout_a, 8'h33);
    checkOutput("after_reset_b", dout_b, 8'h33);

    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

endmodule

// File: doc/ram_assign_dp.md
Name: ram_assign_dp

Overview:
- True dual-port synchronous RAM, 256 x 8 by default, with two independent read/write ports (A and B).
- Both ports share one clock.
- Used as general scratch storage where two agents need simultaneous access.
- Defines deterministic rules for same-address collisions and read-during-write.

Parameters:
- DATA_WIDTH, 8, word width in bits.
- ADDR_WIDTH, 8, address width; DEPTH = 2**ADDR_WIDTH words (256).

Ports:
- clk, input, 1, single clock; all activity on its rising edge.
- rst, input, 1, reset, synchronous, active-high.
- add_a, input, ADDR_WIDTH, port A address.
- din_a, input, DATA_WIDTH, port A write data.
- we_a, input, 1, port A write enable.
- dout_a, output, DATA_WIDTH, port A registered read data.
- add_b, input, ADDR_WIDTH, port B address.
- din_b, input, DATA_WIDTH, port B write data.
- we_b, input, 1, port B write enable.
- dout_b, output, DATA_WIDTH, port B registered read data.

Behaviour:
- Storage: DEPTH words of DATA_WIDTH, all zero at power-up / simulation start.
- Reset:
  - rst=1 at a rising edge sets dout_a=0 and dout_b=0.
  - Memory contents are unchanged by reset.
  - Writes are suppressed while rst=1 (we_a/we_b ignored).
- Normal edge (rst=0), each port independently:
  - if we_x=1, mem[add_x] <= din_x;
  - dout_x <= the word at add_x after this edge's writes are resolved.
- Latency:
  - Read data appears on dout_x one cycle after the address is presented.
  - dout_x holds its value until the next edge.
- Write-first on the writing port: with we_a=1, dout_a equals din_a at the next edge. Same for B.
- Cross-port read-during-write (A writes address X while B reads X with we_b=0): dout_b returns the new data, din_a. Symmetric for B writing and A reading.
- Simultaneous writes to the same address (we_a=we_b=1, add_a==add_b):
  - Port A wins: mem gets din_a, port B's write is discarded.
  - Both dout_a and dout_b show din_a.
- Simultaneous writes to different addresses: both take effect in the same cycle.
- Both ports reading the same address: both get the same word; no conflict.
- Address range is the full 2**ADDR_WIDTH; no out-of-range case and no wrap logic needed.
- Reset asserted mid-sequence:
  - outputs go to 0 on that edge;
  - a write presented on that same edge is lost;
  - earlier stored data survives and is readable after rst deasserts.
- No X propagation: outputs are always driven.

Decomposition:
- Shared package ram_assign_pkg holds:
  - DATA_WIDTH / ADDR_WIDTH defaults;
  - DEPTH derivation;
  - typedefs for data word and address.
- Collision and forwarding logic is small and stays inline.
- No sub-module; a single module is natural.

Test Plan:
- Reset: drive rst=1 for 2 cycles with we_a=we_b=1, din_a=0xAA, din_b=0x55 -> dout_a=dout_b=0x00; afterwards reading addresses 0..7 returns 0x00 (no writes occurred).
- Same-address dual write: for i=0..7, one cycle with add_a=add_b=i, din_a=3i, din_b=5i, we_a=we_b=1, then one idle cycle -> both douts show 3i after each write edge. A read-back pass on port B then returns 0,3,6,...,21 at addresses 0..7.
- Distinct-address dual write: A writes 0x11 to addr 0x10 while B writes 0x22 to addr 0x20 -> next cycle A reading 0x20 gives 0x22 and B reading 0x10 gives 0x11.
- Cross-port forwarding: A writes 0x5A to addr 0x40 while B reads 0x40 with we_b=0 -> dout_b=0x5A at that edge.
- Registered latency: write 0x77 at addr 0xFF, then change add_a from 0x00 to 0xFF -> dout_a shows 0x77 exactly one edge after the address change, not before.
- Reset mid-operation: store 0x33 at addr 5, assert rst for one cycle while presenting a write of 0x99 to addr 5 -> douts go to 0; afterwards addr 5 reads 0x33.
